// File: rtl/toggle_divider.sv
// toggle_divider: programmable square-wave divider with tick strobe and glitch-free divisor reload
module toggle_divider #(
  parameter int WIDTH = 8,
  parameter int unsigned RESET_DIV = 1
) (
  input  logic             CK,
  input  logic             RB,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LD,
  input  logic [WIDTH-1:0] DIV,
  output logic             Q,
  output logic             TICK,
  output logic             PEND,
  output logic [WIDTH-1:0] CNT
);
  logic [WIDTH-1:0] div_in, div_act, div_pend;
  logic wrap;
  // zero divisor behaves as one; a wrap ends the current half-period
  always_comb begin
    div_in = (DIV == '0) ? WIDTH'(1) : DIV;
    wrap = EN && !CLR && (CNT == div_act - WIDTH'(1));
  end
  // period boundaries (clear or wrap) adopt the newest divisor; elsewhere loads are staged
  always_ff @(posedge CK or negedge RB) begin
    if (!RB) begin
      CNT <= '0;
      Q <= 1'b0;
      TICK <= 1'b0;
      PEND <= 1'b0;
      div_act <= WIDTH'(RESET_DIV);
      div_pend <= WIDTH'(RESET_DIV);
    end else if (CLR || wrap) begin
      CNT <= '0;
      Q <= CLR ? 1'b0 : ~Q;
      TICK <= wrap;
      PEND <= 1'b0;
      div_act <= LD ? div_in : PEND ? div_pend : div_act;
    end else begin
      CNT <= EN ? CNT + WIDTH'(1) : CNT;
      TICK <= 1'b0;
      if (LD) begin
        div_pend <= div_in;
        PEND <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_toggle_divider.sv
// tb_toggle_divider: table vectors, corner sequences and random run against a behavioural model
module tb_toggle_divider;
  localparam int W = 4;
  logic CK = 0, RB = 0, EN = 0, CLR = 0, LD = 0;
  logic [W-1:0] DIV = '0;
  logic Q, TICK, PEND;
  logic [W-1:0] CNT;
  int passed = 0, total = 0;
  int m_pos, m_half, m_level, m_tick, m_have_next, m_next;

  toggle_divider #(.WIDTH(W), .RESET_DIV(1)) dut (
    .CK(CK), .RB(RB), .EN(EN), .CLR(CLR), .LD(LD), .DIV(DIV),
    .Q(Q), .TICK(TICK), .PEND(PEND), .CNT(CNT)
  );

  always #5 CK = ~CK;

  typedef struct {
    bit en, clr, ld;
    int div;
    int q, tick, pend, cnt;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = 0; m_half = 1; m_level = 0; m_tick = 0; m_have_next = 0; m_next = 1;
  endtask

  // behavioural view: elapsed cycles in the half-period vs its length
  task automatic model_step(input bit en, input bit clr, input bit ld, input int div);
    int d;
    d = (div == 0) ? 1 : div;
    if (clr) begin
      m_pos = 0; m_level = 0; m_tick = 0;
      m_half = ld ? d : (m_have_next ? m_next : m_half);
      m_have_next = 0;
    end else if (en && m_pos + 1 == m_half) begin
      m_pos = 0; m_level = 1 - m_level; m_tick = 1;
      m_half = ld ? d : (m_have_next ? m_next : m_half);
      m_have_next = 0;
    end else begin
      if (en) m_pos++;
      m_tick = 0;
      if (ld) begin m_next = d; m_have_next = 1; end
    end
  endtask

  task automatic cyc(input bit en, input bit clr, input bit ld, input int div);
    EN = en; CLR = clr; LD = ld; DIV = W'(div);
    model_step(en, clr, ld, div);
    @(posedge CK); #1;
    check("q", int'(Q), m_level);
    check("tick", int'(TICK), m_tick);
    check("pend", int'(PEND), m_have_next);
    check("cnt", int'(CNT), m_pos);
  endtask

  task automatic run_half(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, 0);
      n++;
      if (TICK) break;
    end
  endtask

  initial begin
    vec_t tbl[16];
    int n, mx;
    tbl = '{
      '{0,0,1,3, 0,0,1,0}, '{0,1,0,0, 0,0,0,0}, '{1,0,0,0, 0,0,0,1}, '{1,0,0,0, 0,0,0,2},
      '{1,0,0,0, 1,1,0,0}, '{1,0,0,0, 1,0,0,1}, '{1,0,0,0, 1,0,0,2}, '{1,0,0,0, 0,1,0,0},
      '{1,0,1,0, 0,0,1,1}, '{1,0,0,0, 0,0,1,2}, '{1,0,0,0, 1,1,0,0}, '{1,0,0,0, 0,1,0,0},
      '{0,0,0,0, 0,0,0,0}, '{1,0,1,2, 1,1,0,0}, '{1,0,0,0, 1,0,0,1}, '{1,0,0,0, 0,1,0,0}
    };
    model_reset();
    @(posedge CK); #1;
    check("rst_q", int'(Q), 0); check("rst_tick", int'(TICK), 0);
    check("rst_pend", int'(PEND), 0); check("rst_cnt", int'(CNT), 0);
    RB = 1;
    // default divisor of one: plain toggle flip-flop
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0);
      check("dflt_q", int'(Q), (i + 1) % 2);
      check("dflt_tick", int'(TICK), 1);
    end
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].en, tbl[i].clr, tbl[i].ld, tbl[i].div);
      check("tbl_q", int'(Q), tbl[i].q);
      check("tbl_tick", int'(TICK), tbl[i].tick);
      check("tbl_pend", int'(PEND), tbl[i].pend);
      check("tbl_cnt", int'(CNT), tbl[i].cnt);
    end
    // maximum divisor
    cyc(0, 1, 1, 15);
    mx = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 0, 0, 0);
      n++;
      if (int'(CNT) > mx) mx = int'(CNT);
      if (TICK) break;
    end
    check("max_half", n, 15);
    check("max_cnt", mx, 14);
    // mid-period reload: old half-period completes first
    cyc(0, 1, 1, 4);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 2);
    check("mid_pend", int'(PEND), 1);
    run_half(n);
    check("mid_old_half", n + 2, 4);
    check("mid_pend_clr", int'(PEND), 0);
    run_half(n);
    check("mid_new_half", n, 2);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 3);
    check("wrap_ld_tick", int'(TICK), 1);
    check("wrap_ld_pend", int'(PEND), 0);
    run_half(n);
    check("wrap_ld_half", n, 3);
    // enable gap stretches the half-period
    cyc(0, 1, 1, 3);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      check("gap_cnt", int'(CNT), 1);
      check("gap_tick", int'(TICK), 0);
    end
    run_half(n);
    check("gap_rest", n, 2);
    // asynchronous reset mid-operation
    cyc(0, 1, 1, 4);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 7);
    check("pre_q", int'(Q), 1); check("pre_cnt", int'(CNT), 2); check("pre_pend", int'(PEND), 1);
    #2 RB = 0;
    #1;
    check("arst_q", int'(Q), 0); check("arst_tick", int'(TICK), 0);
    check("arst_pend", int'(PEND), 0); check("arst_cnt", int'(CNT), 0);
    @(posedge CK); #1;
    RB = 1;
    model_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 500; i++)
      cyc($urandom % 4 != 0, $urandom % 20 == 0, $urandom % 6 == 0, int'($urandom % 16));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/toggle_divider.md
# toggle_divider

Parametrised successor of the single toggle flip-flop (inverted-feedback divide-by-2). It generates a square wave `Q` that toggles every `N` enabled clock cycles, plus a one-cycle `TICK` pulse at each toggle. `N` is run-time programmable through a shadow register that updates glitch-free at period boundaries. It sits next to the clock generator and supplies slow strobes and divided square waves to downstream logic, all synchronous to `CK`.

## Interface
- `WIDTH`, default 8: width of counter and divisor.
- `RESET_DIV`, default 1: divisor loaded into active and pending registers at reset. Must be in 1..2^WIDTH-1.
- `CK`  input  1  clock, rising-edge.
- `RB`  input  1  reset, asynchronous, active-low.
- `EN`  input  1  count enable. 0 holds counter, `Q` and the divisor state.
- `CLR`  input  1  synchronous restart. Clears count and phase, applies any pending divisor.
- `LD`  input  1  load strobe. Captures `DIV` on the rising edge where `LD`=1.
- `DIV`  input  WIDTH  requested divisor `N`. 0 is treated as 1.
- `Q`  output  1  divided square wave. Period is 2·N enabled cycles.
- `TICK`  output  1  one-cycle pulse, high in the cycle after each `Q` toggle.
- `PEND`  output  1  a loaded divisor is waiting for the next period boundary.
- `CNT`  output  WIDTH  current count, 0..N-1.

## Operation
- **Internal state**
  - `cnt` (WIDTH bits).
  - `div_act`: active divisor.
  - `div_pend`: pending divisor.
  - `pend` flag and `q` register.
- **Outputs**: all outputs are registered and come directly from flops. `CNT`=`cnt`, `PEND`=`pend`.
- **Divisor sanitising**: `DIV`=0 is stored as 1. No other arithmetic. `cnt` never exceeds `div_act-1`.
- **Wrap**: a wrap is an edge with `EN`=1, `CLR`=0 and `cnt`==`div_act-1`.
- **Per-edge priority** (first match wins):
  1. **`CLR`=1**
     - `cnt`←0, `q`←0, `TICK`←0.
     - If `LD`=1: `div_act`←sanitised `DIV`.
     - Else if `pend`=1: `div_act`←`div_pend`.
     - `pend`←0.
  2. **Wrap**
     - `cnt`←0, `q`←~`q`, `TICK`←1.
     - If `LD`=1: `div_act`←sanitised `DIV`. This has the same effect as an immediate load.
     - Else if `pend`=1: `div_act`←`div_pend`.
     - `pend`←0.
  3. **`EN`=1, no wrap**
     - `cnt`←`cnt`+1, `TICK`←0.
     - If `LD`=1: `div_pend`←sanitised `DIV`, `pend`←1.
  4. **`EN`=0**
     - `cnt` and `q` hold, `TICK`←0.
     - If `LD`=1: `div_pend`←sanitised `DIV`, `pend`←1.
- **Repeated loads**: a second `LD` while `pend`=1 overwrites `div_pend` (last write wins). `pend` stays 1.
- **Divisor of 1**: every enabled edge is a wrap. `q` toggles every cycle and `TICK` stays high. This exactly reproduces the original toggle flip-flop.
- **Divisor changes are glitch-free**: the current half-period always completes with the old divisor.

## Timing
- **Reset** (`RB`=0, asynchronous, no clock needed):
  - `Q`=0, `TICK`=0, `PEND`=0, `CNT`=0.
  - `div_act`=`div_pend`=`RESET_DIV`.
- **Reset release**: the first counting edge is the first rising `CK` with `RB`=1 and `EN`=1.
- **Reset mid-period**: aborts the period and discards any pending divisor.
- **Toggle timing**: with `EN` held high after a wrap, the next wrap occurs exactly N edges later. `Q` high and low phases are each N cycles.
- **`TICK` latency**: high for exactly the one cycle following the wrap edge. It coincides with the first cycle of the new `Q` level.
- **`LD` to effect**:
  - New divisor governs the half-period starting at the next wrap or `CLR`.
  - If `LD` coincides with a wrap or `CLR`, it governs the half-period starting at that edge.
- **`EN` gaps**: stretch the current half-period cycle-for-cycle with no loss of count. `TICK` is never asserted during `EN`=0.

## Test plan
- **Reset default** (`RESET_DIV`=1): release `RB`, `EN`=1 → `Q` toggles every edge (0,1,0,1…), `TICK`=1 from the first edge onward, `CNT`=0 throughout.
- **Divide by 3**: `LD` with `DIV`=3 while `EN`=0, then `CLR` pulse, then `EN`=1 → `PEND` 1 then 0 after `CLR`; `CNT` 0,1,2,0…; `Q` period 6 cycles; `TICK` high every third cycle.
- **Mid-period reload**: running with `DIV`=4, `LD` `DIV`=2 at `CNT`=1 → `PEND`=1; the current half-period still lasts 4 cycles; subsequent half-periods are 2 cycles; `PEND`=0 after the wrap. `LD` on the wrap edge itself → takes effect with no `PEND`.
- **Zero and maximum divisor**: `DIV`=0 → identical to `DIV`=1. `WIDTH`=4, `DIV`=15 → `CNT` reaches 14 and wraps, half-period 15 cycles.
- **Enable gaps**: `DIV`=3, drop `EN` for 5 cycles at `CNT`=1 → `CNT`, `Q` hold and `TICK`=0 during the gap; the wrap is delayed by exactly 5 cycles.
- **Asynchronous reset mid-operation**: assert `RB` between edges with `Q`=1, `CNT`=2, `PEND`=1 → all outputs are 0 immediately; after release the block counts with `RESET_DIV`.
